lif_frame_sequencer: RTL and testbench
======================================

Name: lif_frame_sequencer

Overview:
Upstream control stage for the LIF neuron core. Accepts a byte stream over a valid/ready handshake and parses it into frames: one header byte, then the weight or input vector bytes. Issues per-byte load strobes to the neuron's shift registers, then runs a programmed number of integration ticks while counting output spikes. Replaces manual switch-driven loading with a self-timed load/integrate/report sequence.

Parameters:
N_STAGES, 5, neuron adder-tree depth; vector width = 2**N_STAGES bits (N_STAGES >= 3)
PAYLOAD_BYTES, 2**N_STAGES/8 (derived localparam, 4 at default), payload bytes per frame
COUNT_BITS, 8, spike counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_data  in  8  stream byte
in_valid  in  1  upstream byte valid
in_ready  out  1  block accepts byte this cycle
nrn_data  out  8  byte to shift into neuron (= in_data)
nrn_load  out  1  strobe: shift nrn_data into the selected register this cycle
nrn_load_weights  out  1  1 = strobe targets weights, 0 = inputs (qualifies nrn_load)
nrn_integrate  out  1  strobe: neuron commits new_membrane this cycle
nrn_spike  in  1  neuron spike (combinational from current membrane/inputs)
busy  out  1  frame in progress (state != IDLE)
done  out  1  one-cycle pulse at frame end
spike_count  out  COUNT_BITS  spikes counted in last input frame

Behaviour:
- Accept = in_valid & in_ready. Byte transfers only on accept; in_valid may drop at any time without loss.
- Header byte: bit7 = kind (1 weights, 0 inputs); bits[6:0] = ticks (0..127). Ticks ignored for weight frames.
- States: IDLE, LOAD, INTEGRATE, DONE.
- IDLE: in_ready=1. Accept -> latch kind/ticks, clear byte counter, clear spike_count to 0 -> LOAD next cycle. No strobes from the header byte.
- LOAD: in_ready=1. nrn_load = accept (combinational, same cycle); nrn_data = in_data; nrn_load_weights = latched kind. Byte counter increments per accept. On accept of byte PAYLOAD_BYTES-1 (0-based): next state INTEGRATE if kind=0 and ticks>0, else DONE.
- INTEGRATE: in_ready=0, nrn_integrate=1 every cycle for exactly ticks cycles (tick counter decrements from ticks to 1), then DONE. Each integrate cycle with nrn_spike=1 increments spike_count, saturating at 2**COUNT_BITS-1 (no wrap).
- DONE: in_ready=0, done=1 for exactly one cycle -> IDLE.
- nrn_load and nrn_integrate never high in the same cycle; both 0 in IDLE and DONE. nrn_data is don't-care when nrn_load=0, but drives in_data.
- spike_count holds its value from DONE until the next header accept; weight frames leave it at 0.
- Cycle timing, input frame with ticks=T: last payload accepted at cycle t -> nrn_integrate high cycles t+1..t+T -> done at t+T+1 -> in_ready=1 at t+T+2. Weight frame: last byte at t -> done at t+1.
- Minimum frame duration (no stalls): 1 + PAYLOAD_BYTES + ticks + 1 cycles.
- No timeout: a stalled frame waits in LOAD indefinitely.
- Reset (any state, including mid-LOAD or mid-INTEGRATE): next cycle state=IDLE, byte/tick counters=0, kind=0, ticks=0, spike_count=0. Outputs: in_ready=1, busy=0, done=0, nrn_load=0, nrn_integrate=0, nrn_load_weights=0. A partially loaded neuron vector is not rolled back.
- busy = 1 in LOAD, INTEGRATE, DONE.

Test Plan:
- Weight frame: bytes 0x80, 0xFF, 0x0F, 0xAA, 0x55 back-to-back -> four nrn_load pulses with nrn_load_weights=1 and data FF,0F,AA,55; nrn_integrate never high; done one cycle after the 0x55 accept; spike_count=0.
- Input frame: 0x03, 4 payload bytes, nrn_spike forced high -> nrn_integrate high for exactly 3 cycles immediately after the last load; done next cycle; spike_count=3.
- Stalls: input frame 0x02 with in_valid low for 5 cycles between bytes 2 and 3 -> no extra nrn_load strobes, same data order, frame completes, busy high throughout.
- Saturation: COUNT_BITS=4, header 0x7F, nrn_spike=1 -> 127 integrate cycles, spike_count=15.
- Zero ticks: header 0x00 + 4 bytes -> done one cycle after the last byte, no nrn_integrate; header 0x85 (weights, ticks=5) -> ticks ignored.
- Reset mid-INTEGRATE after 2 of 10 ticks -> next cycle IDLE, in_ready=1, spike_count=0, strobes low; a following frame runs normally.

Source files
------------

// File: rtl/lif_frame_sequencer.sv
// Frame sequencer for the LIF neuron core: parses header + payload bytes from a
// valid/ready stream, strobes neuron loads, then runs the programmed integration ticks.
module lif_frame_sequencer #(
    parameter int N_STAGES   = 5,
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            nrn_data,
    output logic                  nrn_load,
    output logic                  nrn_load_weights,
    output logic                  nrn_integrate,
    input  logic                  nrn_spike,
    output logic                  busy,
    output logic                  done,
    output logic [COUNT_BITS-1:0] spike_count
);

    localparam int PAYLOAD_BYTES = (2 ** N_STAGES) / 8;
    // One extra count of headroom keeps the counter at least one bit wide for single-byte payloads.
    localparam int BYTE_BITS = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [BYTE_BITS-1:0]  LAST_BYTE = BYTE_BITS'(PAYLOAD_BYTES - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        INTEGRATE = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    kind_r;
    logic [6:0]              ticks_r;
    logic [6:0]              tick_cnt_r;
    logic [BYTE_BITS-1:0]    byte_cnt_r;
    logic [COUNT_BITS-1:0]   spike_count_r;
    logic                    accept_s;

    assign accept_s    = in_valid & in_ready;
    assign nrn_data    = in_data;
    assign spike_count = spike_count_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s && (byte_cnt_r == LAST_BYTE)) begin
                    if (!kind_r && (ticks_r != 7'd0)) begin
                        next_state_s = INTEGRATE;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = LOAD;
                end
            end
            INTEGRATE: begin
                // Counter runs ticks..1; <=1 also guards against a zero count.
                if (tick_cnt_r <= 7'd1) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = INTEGRATE;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode; the load strobe follows the handshake combinationally.
    always_comb begin
        in_ready         = 1'b0;
        nrn_load         = 1'b0;
        nrn_load_weights = 1'b0;
        nrn_integrate    = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
            end
            LOAD: begin
                in_ready         = 1'b1;
                nrn_load         = in_valid;
                nrn_load_weights = kind_r;
                busy             = 1'b1;
            end
            INTEGRATE: begin
                nrn_integrate = 1'b1;
                busy          = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Frame context, byte/tick counters and saturating spike counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_r        <= 1'b0;
            ticks_r       <= 7'd0;
            tick_cnt_r    <= 7'd0;
            byte_cnt_r    <= '0;
            spike_count_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        kind_r        <= in_data[7];
                        ticks_r       <= in_data[6:0];
                        tick_cnt_r    <= in_data[6:0];
                        byte_cnt_r    <= '0;
                        spike_count_r <= '0;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + BYTE_BITS'(1);
                    end
                end
                INTEGRATE: begin
                    tick_cnt_r <= tick_cnt_r - 7'd1;
                    if (nrn_spike && (spike_count_r != COUNT_MAX)) begin
                        spike_count_r <= spike_count_r + COUNT_BITS'(1);
                    end
                end
                default: begin
                    spike_count_r <= spike_count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_frame_sequencer.sv
// Directed + randomized bench for lif_frame_sequencer; expected behaviour comes from
// frame-level rules (load list, tick count, saturating spike sum), not from RTL state.
module tb_lif_frame_sequencer;

    localparam int NS   = 5;
    localparam int CB   = 4;
    localparam int P    = (2 ** NS) / 8;
    localparam int MAXC = (2 ** CB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    nrn_data;
    logic          nrn_load;
    logic          nrn_load_weights;
    logic          nrn_integrate;
    logic          nrn_spike;
    logic          busy;
    logic          done;
    logic [CB-1:0] spike_count;

    int n_vec = 0;
    int n_err = 0;

    lif_frame_sequencer #(.N_STAGES(NS), .COUNT_BITS(CB)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .nrn_data         (nrn_data),
        .nrn_load         (nrn_load),
        .nrn_load_weights (nrn_load_weights),
        .nrn_integrate    (nrn_integrate),
        .nrn_spike        (nrn_spike),
        .busy             (busy),
        .done             (done),
        .spike_count      (spike_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame: header, payload with st[i] idle cycles before byte i, then ticks.
    // spk_mode: 0 spike low, 1 spike high, 2 random. abort_at>0 resets after that many ticks.
    task automatic run_frame(input logic [7:0] hdr, input logic [7:0] pl [P],
                             input int st [P], input int spk_mode, input int abort_at);
        logic kind;
        int   t_eff;
        int   sum;
        int   exp_cnt;
        logic s;
        kind  = hdr[7];
        t_eff = kind ? 0 : int'(hdr[6:0]);
        sum   = 0;

        @(negedge clk);
        in_valid = 1'b1; in_data = hdr; nrn_spike = 1'($urandom); #1;
        check("hdr_ready", in_ready, 1);
        check("hdr_busy", busy, 0);
        check("hdr_noload", nrn_load, 0);

        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < st[i]; j++) begin
                @(negedge clk);
                in_valid = 1'b0; in_data = 8'($urandom); #1;
                check("stall_noload", nrn_load, 0);
                check("stall_busy", busy, 1);
                check("stall_ready", in_ready, 1);
            end
            @(negedge clk);
            in_valid = 1'b1; in_data = pl[i]; #1;
            check("load_strobe", nrn_load, 1);
            check("load_data", nrn_data, pl[i]);
            check("load_kind", nrn_load_weights, kind);
            check("load_noint", nrn_integrate, 0);
        end

        for (int k = 1; k <= t_eff; k++) begin
            s = (spk_mode == 1) ? 1'b1 : ((spk_mode == 0) ? 1'b0 : 1'($urandom));
            sum += int'(s);
            @(negedge clk);
            in_valid = 1'($urandom); in_data = 8'($urandom); nrn_spike = s; #1;
            check("int_strobe", nrn_integrate, 1);
            check("int_ready", in_ready, 0);
            check("int_noload", nrn_load, 0);
            check("int_nodone", done, 0);
            if (k == abort_at) begin
                @(negedge clk);
                reset = 1'b1; in_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0; #1;
                check("rst_ready", in_ready, 1);
                check("rst_busy", busy, 0);
                check("rst_count", spike_count, 0);
                check("rst_int", nrn_integrate, 0);
                check("rst_done", done, 0);
                check("rst_wts", nrn_load_weights, 0);
                return;
            end
        end

        exp_cnt = (sum > MAXC) ? MAXC : sum;
        @(negedge clk);
        in_valid = 1'($urandom); nrn_spike = 1'($urandom); #1;
        check("done_pulse", done, 1);
        check("done_noint", nrn_integrate, 0);
        check("done_noload", nrn_load, 0);
        check("done_ready", in_ready, 0);
        check("done_count", spike_count, exp_cnt);

        @(negedge clk);
        in_valid = 1'b0; #1;
        check("idle_done", done, 0);
        check("idle_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_count", spike_count, exp_cnt);
    endtask

    initial begin
        logic [7:0] pl [P];
        int         st [P];
        logic [7:0] hdr;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; nrn_spike = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0; #1;
        check("reset_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_load", nrn_load, 0);
        check("reset_int", nrn_integrate, 0);
        check("reset_count", spike_count, 0);

        // Weight frame, back-to-back.
        pl = '{8'hFF, 8'h0F, 8'hAA, 8'h55};
        st = '{0, 0, 0, 0};
        run_frame(8'h80, pl, st, 2, 0);

        // Input frame, 3 ticks, spike held high.
        pl = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_frame(8'h03, pl, st, 1, 0);

        // Stall of 5 cycles inside the payload.
        st = '{0, 0, 5, 0};
        run_frame(8'h02, pl, st, 1, 0);

        // Saturation: 127 spiking ticks into a 4-bit counter.
        st = '{0, 0, 0, 0};
        run_frame(8'h7F, pl, st, 1, 0);

        // Zero ticks, and weight frame with ticks that must be ignored.
        run_frame(8'h00, pl, st, 1, 0);
        run_frame(8'h85, pl, st, 1, 0);

        // Reset after 2 of 10 ticks, then a normal frame.
        run_frame(8'h0A, pl, st, 1, 2);
        run_frame(8'h04, pl, st, 1, 0);

        // Randomized frames.
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < P; i++) begin
                pl[i] = 8'($urandom);
                st[i] = int'($urandom_range(0, 2));
            end
            hdr = {1'($urandom), 7'($urandom_range(0, 20))};
            run_frame(hdr, pl, st, 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
